// File: rtl/grid_pkg.sv
// ============================================================================
// grid_pkg : shared types and sizes for the VGA tile-grid Avalon writer
// Revision : 1.0
// ============================================================================
`default_nettype none

package grid_pkg;

    localparam int GRID_WORDS  = 16;
    localparam int GRID_IDX_W  = 4;
    localparam int GRID_DATA_W = 16;

    typedef enum logic {
        GW_IDLE  = 1'b0,
        GW_WRITE = 1'b1
    } gw_state_t;

    typedef logic [15:0] grid_word_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick16.sv
// ============================================================================
// rr_pick16 : combinational round-robin picker; first set request after 'last'
// Revision  : 1.0
// ============================================================================
`default_nettype none

module rr_pick16
    import grid_pkg::*;
#(
    parameter  int N = GRID_WORDS,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] sel,
    output logic         any
);

    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit after 'last' wins;
    // offset N wraps back onto 'last' itself, giving it lowest priority.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = last + W'(k);
            if (req[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/grid_avl_writer.sv
// ============================================================================
// grid_avl_writer : shadow tile grid + dirty mask, flushed to the display
//                   slave as round-robin Avalon-MM single-word writes
// Revision        : 1.0
// ============================================================================
`default_nettype none

module grid_avl_writer
    import grid_pkg::*;
#(
    parameter  int GRID_WORDS = 16,
    parameter  int DATA_W     = 16,
    localparam int IDX_W      = $clog2(GRID_WORDS)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              UPD_VALID,
    input  logic [IDX_W-1:0]  UPD_ADDR,
    input  logic [DATA_W-1:0] UPD_DATA,
    input  logic              FLUSH,
    output logic              AVL_WRITE,
    output logic              AVL_CS,
    output logic [IDX_W:0]    AVL_ADDR,
    output logic [DATA_W-1:0] AVL_WRITEDATA,
    input  logic              AVL_WAITREQUEST,
    output logic              BUSY
);

    gw_state_t               state_q, state_d;
    logic [GRID_WORDS-1:0]   dirty_q, dirty_d;
    logic [IDX_W-1:0]        last_q,  last_d;
    logic                    write_q, write_d;
    logic [IDX_W:0]          addr_q,  addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       shadow_q [GRID_WORDS];

    logic [IDX_W-1:0]        pick_sel;
    logic                    pick_any;

    rr_pick16 #(
        .N    (GRID_WORDS)
    ) u_pick (
        .req  (dirty_q),
        .last (last_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < GRID_WORDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (UPD_VALID) begin
            shadow_q[UPD_ADDR] <= UPD_DATA;
        end
    end

    always_comb begin
        state_d = state_q;
        dirty_d = dirty_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            GW_IDLE: begin
                if (pick_any) begin
                    state_d           = GW_WRITE;
                    write_d           = 1'b1;
                    addr_d            = {1'b0, pick_sel};
                    wdata_d           = shadow_q[pick_sel];
                    dirty_d[pick_sel] = 1'b0;
                    last_d            = pick_sel;
                end
            end
            GW_WRITE: begin
                if (!AVL_WAITREQUEST) begin
                    state_d = GW_IDLE;
                    write_d = 1'b0;
                end
            end
        endcase

        // Applied after the clear so a same-edge update re-dirties the entry.
        if (FLUSH) begin
            dirty_d = '1;
        end
        if (UPD_VALID) begin
            dirty_d[UPD_ADDR] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= GW_IDLE;
            dirty_q <= '1;
            last_q  <= '1;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            dirty_q <= dirty_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign AVL_WRITE     = write_q;
    assign AVL_CS        = write_q;
    assign AVL_ADDR      = addr_q;
    assign AVL_WRITEDATA = wdata_q;
    assign BUSY          = (|dirty_q) | (state_q == GW_WRITE);

endmodule

`default_nettype wire

// File: tb/tb_grid_avl_writer.sv
// ============================================================================
// tb_grid_avl_writer : directed + random bench with a transaction-level model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_grid_avl_writer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        UPD_VALID;
    logic [3:0]  UPD_ADDR;
    logic [15:0] UPD_DATA;
    logic        FLUSH;
    logic        AVL_WRITE;
    logic        AVL_CS;
    logic [4:0]  AVL_ADDR;
    logic [15:0] AVL_WRITEDATA;
    logic        AVL_WAITREQUEST;
    logic        BUSY;

    int vectors     = 0;
    int miscompares = 0;

    always #10 CLK = ~CLK;

    grid_avl_writer dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .UPD_VALID       (UPD_VALID),
        .UPD_ADDR        (UPD_ADDR),
        .UPD_DATA        (UPD_DATA),
        .FLUSH           (FLUSH),
        .AVL_WRITE       (AVL_WRITE),
        .AVL_CS          (AVL_CS),
        .AVL_ADDR        (AVL_ADDR),
        .AVL_WRITEDATA   (AVL_WRITEDATA),
        .AVL_WAITREQUEST (AVL_WAITREQUEST),
        .BUSY            (BUSY)
    );

    // Reference model: grid contents, pending set, last-served index, one
    // outstanding transfer at most.
    logic [15:0] m_shadow [16];
    bit          m_dirty  [16];
    int          m_last;
    bit          m_write;
    int          m_addr;
    logic [15:0] m_data;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 16; i++) begin
                m_shadow[i] = 16'h0;
                m_dirty[i]  = 1'b1;
            end
            m_last  = 15;
            m_write = 1'b0;
            m_addr  = 0;
            m_data  = 16'h0;
        end else begin
            if (m_write) begin
                if (!AVL_WAITREQUEST) m_write = 1'b0;
            end else begin
                bit found;
                found = 1'b0;
                for (int off = 1; off <= 16; off++) begin
                    int idx;
                    idx = (m_last + off) % 16;
                    if (!found && m_dirty[idx]) begin
                        found         = 1'b1;
                        m_write       = 1'b1;
                        m_addr        = idx;
                        m_data        = m_shadow[idx];
                        m_dirty[idx]  = 1'b0;
                        m_last        = idx;
                    end
                end
            end
            if (FLUSH) begin
                for (int i = 0; i < 16; i++) m_dirty[i] = 1'b1;
            end
            if (UPD_VALID) begin
                m_shadow[UPD_ADDR] = UPD_DATA;
                m_dirty[UPD_ADDR]  = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        bit         exp_busy;
        logic [4:0] exp_addr;
        exp_busy = m_write;
        for (int i = 0; i < 16; i++) exp_busy = exp_busy | m_dirty[i];
        exp_addr = 5'(m_addr);
        vectors++;
        if (AVL_WRITE !== m_write || AVL_CS !== m_write || AVL_ADDR !== exp_addr ||
            AVL_WRITEDATA !== m_data || BUSY !== exp_busy) begin
            miscompares++;
            $display("FAIL cycle-compare t=%0t: dut wr=%b cs=%b addr=%0d data=%h busy=%b, want wr=%b addr=%0d data=%h busy=%b",
                     $time, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA, BUSY,
                     m_write, exp_addr, m_data, exp_busy);
        end
    end

    // Completed-transfer log and write-high cycle counter for directed checks.
    int          obs_addr [$];
    logic [15:0] obs_data [$];
    int          wr_hi;

    always @(negedge CLK) begin
        if (RESET_N && AVL_WRITE) begin
            wr_hi++;
            if (!AVL_WAITREQUEST) begin
                obs_addr.push_back(int'(AVL_ADDR));
                obs_data.push_back(AVL_WRITEDATA);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        obs_addr.delete();
        obs_data.delete();
        wr_hi = 0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (BUSY && n < max_cycles) begin
            cyc(1);
            n++;
        end
        check("idle-within-bound", 32'(BUSY), 32'd0);
    endtask

    task automatic upd(input logic [3:0] a, input logic [15:0] d);
        UPD_VALID = 1'b1;
        UPD_ADDR  = a;
        UPD_DATA  = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; UPD_VALID = 1'b0; UPD_ADDR = '0; UPD_DATA = '0;
        FLUSH = 1'b0; AVL_WAITREQUEST = 1'b0; wr_hi = 0;
        cyc(3);
        check("reset-write", 32'(AVL_WRITE), 32'd0);
        check("reset-busy",  32'(BUSY), 32'd1);
        check("reset-addr",  32'(AVL_ADDR), 32'd0);

        // Post-reset clear of the whole display
        clear_log();
        RESET_N = 1'b1;
        wait_idle(100);
        check("reset-flush-count", 32'(obs_addr.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("reset-flush-addr", 32'(obs_addr[i]), 32'(i));
            check("reset-flush-data", 32'(obs_data[i]), 32'h0);
        end

        // Single update latency
        clear_log();
        upd(4'd5, 16'hA5C3);
        cyc(1);
        UPD_VALID = 1'b0;
        check("single-t1-write", 32'(AVL_WRITE), 32'd0);
        check("single-t1-busy",  32'(BUSY), 32'd1);
        cyc(1);
        check("single-t2-write", 32'(AVL_WRITE), 32'd1);
        check("single-t2-addr",  32'(AVL_ADDR), 32'd5);
        check("single-t2-data",  32'(AVL_WRITEDATA), 32'hA5C3);
        wait_idle(20);
        check("single-count", 32'(obs_addr.size()), 32'd1);

        // Three wait states on a write to 9
        clear_log();
        AVL_WAITREQUEST = 1'b1;
        upd(4'd9, 16'h1234);
        cyc(1);
        UPD_VALID = 1'b0;
        cyc(4);
        AVL_WAITREQUEST = 1'b0;
        wait_idle(20);
        check("wait-hi-cycles", 32'(wr_hi), 32'd4);
        check("wait-count", 32'(obs_addr.size()), 32'd1);
        check("wait-addr",  32'(obs_addr[0]), 32'd9);
        check("wait-data",  32'(obs_data[0]), 32'h1234);

        // Update colliding with selection of the same index
        clear_log();
        upd(4'd3, 16'h2222);
        cyc(1);
        upd(4'd3, 16'h1111);
        cyc(1);
        UPD_VALID = 1'b0;
        wait_idle(20);
        check("coll-count",  32'(obs_addr.size()), 32'd2);
        check("coll-addr0",  32'(obs_addr[0]), 32'd3);
        check("coll-data0",  32'(obs_data[0]), 32'h2222);
        check("coll-addr1",  32'(obs_addr[1]), 32'd3);
        check("coll-data1",  32'(obs_data[1]), 32'h1111);

        // Round-robin after serving 7 with {2,7,12} pending
        clear_log();
        AVL_WAITREQUEST = 1'b1;
        upd(4'd7, 16'h0707);
        cyc(1);
        upd(4'd2, 16'h0202);
        cyc(1);
        upd(4'd12, 16'h0C0C);
        cyc(1);
        upd(4'd7, 16'h7777);
        cyc(1);
        UPD_VALID = 1'b0;
        AVL_WAITREQUEST = 1'b0;
        wait_idle(30);
        check("rr-count", 32'(obs_addr.size()), 32'd4);
        check("rr-addr0", 32'(obs_addr[0]), 32'd7);
        check("rr-addr1", 32'(obs_addr[1]), 32'd12);
        check("rr-addr2", 32'(obs_addr[2]), 32'd2);
        check("rr-addr3", 32'(obs_addr[3]), 32'd7);
        check("rr-data3", 32'(obs_data[3]), 32'h7777);

        // FLUSH while a write to 4 is stalled
        clear_log();
        AVL_WAITREQUEST = 1'b1;
        upd(4'd4, 16'h4444);
        cyc(1);
        UPD_VALID = 1'b0;
        cyc(1);
        FLUSH = 1'b1;
        cyc(1);
        FLUSH = 1'b0;
        AVL_WAITREQUEST = 1'b0;
        wait_idle(100);
        check("flush-count", 32'(obs_addr.size()), 32'd17);
        check("flush-first", 32'(obs_addr[0]), 32'd4);
        for (int k = 1; k <= 16; k++) begin
            check("flush-order", 32'(obs_addr[k]), 32'((4 + k) % 16));
        end
        check("flush-data5",  32'(obs_data[1]), 32'hA5C3);
        check("flush-data4",  32'(obs_data[16]), 32'h4444);

        // Random traffic against the model
        repeat (3000) begin
            UPD_VALID       = ($urandom % 3) == 0;
            UPD_ADDR        = 4'($urandom);
            UPD_DATA        = 16'($urandom);
            FLUSH           = ($urandom % 64) == 0;
            AVL_WAITREQUEST = ($urandom % 3) == 0;
            cyc(1);
        end
        UPD_VALID = 1'b0;
        FLUSH = 1'b0;
        AVL_WAITREQUEST = 1'b0;
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/grid_avl_writer.md
# grid_avl_writer

Avalon-MM master that drives the 16-word tile grid register file of the VGA display peripheral. Game logic posts tile-word updates on a simple local port. The block keeps a 16×16-bit shadow copy plus a dirty mask, and issues one Avalon-MM write per dirty entry in round-robin order, honouring waitrequest. It sits between the game-state FSM and the display slave on the same 50 MHz clock.

## Interface
- `GRID_WORDS`, default 16: number of grid words. Must be a power of two; index width is log2 of it.
- `DATA_W`, default 16: grid word width.
- `CLK` in, 1: system clock, 50 MHz, shared with the display slave.
- `RESET_N` in, 1: asynchronous, active-low reset.
- `UPD_VALID` in, 1: update strobe, one word per cycle.
- `UPD_ADDR` in, 4: grid index to update.
- `UPD_DATA` in, 16: new tile word.
- `FLUSH` in, 1: single-cycle pulse that marks all entries dirty.
- `AVL_WRITE` out, 1: Avalon write request.
- `AVL_CS` out, 1: chip select. Equal to `AVL_WRITE`.
- `AVL_ADDR` out, 5: word address `{1'b0, idx}`.
- `AVL_WRITEDATA` out, 16: write data.
- `AVL_WAITREQUEST` in, 1: slave stall. The transfer completes in the first cycle where `AVL_WRITE` is high and this is low.
- `BUSY` out, 1: high while any entry is dirty or a write is in flight.

## Operation
- **Storage:** `shadow[16]`, `dirty[15:0]`, `last_idx[3:0]`.
- **Reset values:**
  - `shadow` = 0, `dirty` = 16'hFFFF (display cleared after reset), `last_idx` = 15.
  - `AVL_WRITE` = `AVL_CS` = 0, `AVL_ADDR` = 0, `AVL_WRITEDATA` = 0, `BUSY` = 1.
- **Update:** when `UPD_VALID` is high, on the edge `shadow[UPD_ADDR]` takes `UPD_DATA` and `dirty[UPD_ADDR]` is set. Updates are never refused.
- **FLUSH:** sets every dirty bit and leaves `shadow` unchanged.
- **FSM** (2 states, in package):
  - IDLE, when `dirty` ≠ 0:
    - Select the first set bit scanning `last_idx+1`, `last_idx+2`, … with mod-16 wrap.
    - Register `AVL_ADDR` = sel, `AVL_WRITEDATA` = `shadow[sel]`, `AVL_WRITE` = `AVL_CS` = 1.
    - Clear `dirty[sel]`, set `last_idx` = sel, go to WRITE.
  - IDLE, when `dirty` = 0: `AVL_WRITE` stays 0.
  - WRITE: hold all Avalon outputs stable. When `AVL_WAITREQUEST` = 0, deassert `AVL_WRITE`/`AVL_CS` on that edge and go to IDLE.
- **Dirty-bit priority on one edge:**
  - An update or FLUSH coinciding with selection of the same index leaves dirty set (set wins over clear).
  - `shadow` takes the new data.
  - The in-flight write carries the old latched data, and the entry is rewritten later.
- **Update during WRITE:** affects only `shadow`/`dirty`; the latched Avalon data never changes mid-transfer.
- **Fairness:** the round-robin pointer keeps a continuously re-dirtied index from starving the others.
- **BUSY:** `(dirty != 0) | (state == WRITE)`, registered-equivalent. It may be computed from registered state only.
- **Reset mid-transfer:** asynchronous drop of `AVL_WRITE`. Acceptable because the slave shares the reset.

## Timing
- All outputs are registered. No combinational path from `AVL_WAITREQUEST` to any output.
- **Latency:** `UPD_VALID` at cycle t with an otherwise idle block gives `dirty` visible at t+1 and `AVL_WRITE` high from t+2.
- **Zero-wait slave:** each write occupies 1 cycle in WRITE plus 1 cycle in IDLE. Sustained throughput is one write per 2 cycles, and a full 16-word flush takes 32 cycles.
- **Wait states:** N cycles of `AVL_WAITREQUEST` = 1 extend WRITE by N cycles.
- **FLUSH while WRITE is in flight:** the current write completes first. The next selection starts at `last_idx+1`.

## Structure
- **Package `grid_pkg`:**
  - `GRID_WORDS` = 16, `GRID_IDX_W` = 4, `GRID_DATA_W` = 16.
  - `typedef enum logic {GW_IDLE, GW_WRITE} gw_state_t`.
  - `typedef logic [15:0] grid_word_t`.
- **Sub-module `rr_pick16`:** combinational round-robin priority encoder.
  - Inputs: `req[15:0]`, `last[3:0]`.
  - Outputs: `sel[3:0]`, `any`.
- The top level holds the shadow array, the dirty mask and the FSM.

## Test plan
- **Reset flush:** release `RESET_N`, keep `AVL_WAITREQUEST` = 0. Expect 16 writes, addresses 0,1,…,15 in order, all data 16'h0000; `BUSY` falls 1 cycle after the last write.
- **Single update:** after idle, `UPD_ADDR` = 5, `UPD_DATA` = 16'hA5C3 at cycle t. Expect `AVL_WRITE` high at t+2 with `AVL_ADDR` = 5 and data A5C3; exactly one write.
- **Wait states:** hold `AVL_WAITREQUEST` = 1 for 3 cycles during a write to address 9. Expect address, data and `AVL_WRITE` stable for 4 cycles and exactly one completed transfer.
- **Collision:** update index 3 to 16'h1111 in the same cycle index 3 is selected (previous shadow 16'h2222). Expect a write of 2222 to address 3 first, then a later write of 1111 to address 3.
- **Round-robin:** after a write to index 7, dirty {2, 7, 12} → writes to 12, then 2, then 7.
- **FLUSH mid-transfer:** assert FLUSH during a WRITE to index 4. Expect that write to complete, then 16 more writes starting at index 5 and wrapping to index 4.
